// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module      : fetch_pkg
// Description : Shared AXI-lite codes and fetch state type for the prefetcher.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [1:0] C_RRESP_OKAY   = 2'b00;
    localparam logic [2:0] C_ARPROT_INSTR = 3'b100;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// Module      : fetch_fifo
// Description : Synchronous FIFO with flush; head entry visible combinationally.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_count != c_cnt_w'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_axil_prefetch.sv
//------------------------------------------------------------------------------
// Module      : fetch_axil_prefetch
// Description : AXI-lite instruction prefetcher with slot reservation, redirect
//               flush and error halt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_axil_prefetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_instr_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_instr_pc,
    output logic                  o_instr_err,
    input  logic                  i_instr_ready,
    output logic [ADDR_WIDTH-1:0] o_axil_araddr,
    output logic [2:0]            o_axil_arprot,
    output logic                  o_axil_arvalid,
    input  logic                  i_axil_arready,
    input  logic [DATA_WIDTH-1:0] i_axil_rdata,
    input  logic [1:0]            i_axil_rresp,
    input  logic                  i_axil_rvalid,
    output logic                  o_axil_rready
);

    localparam int c_inc    = DATA_WIDTH / 8;
    localparam int c_cnt_w  = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_occ_w  = $clog2(FIFO_DEPTH + 1);
    localparam int c_sum_w  = c_occ_w + 1;
    localparam int c_fifo_w = 1 + ADDR_WIDTH + DATA_WIDTH;

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rpc;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_ar_stale;
    logic [c_cnt_w-1:0]    r_outstanding;
    logic [c_cnt_w-1:0]    r_drop_cnt;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_r_retire;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_beat_err;
    logic                  w_issue;
    fetch_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0] w_pc_aligned;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_next;
    logic [c_cnt_w-1:0]    w_out_next;
    logic [c_cnt_w-1:0]    w_drop_load;
    logic [c_occ_w-1:0]    w_fifo_count;
    logic [c_occ_w-1:0]    w_occ_next;
    logic [c_sum_w-1:0]    w_sum;
    logic [c_fifo_w-1:0]   w_fifo_rd;

    assign w_ar_hs    = r_arvalid && i_axil_arready;
    assign w_r_hs     = i_axil_rvalid && r_rready;
    assign w_r_retire = w_r_hs && (r_outstanding != '0);
    assign w_pop      = o_instr_valid && i_instr_ready;
    assign w_beat_err = (i_axil_rresp != C_RRESP_OKAY);
    assign w_push     = w_r_hs && (r_drop_cnt == '0) && !i_redirect_valid;

    assign w_pc_aligned = i_redirect_pc & ~ADDR_WIDTH'(c_inc - 1);

    // An AR accepted after a redirect belongs to the old stream, so it must not
    // advance the new fetch address.
    assign w_fetch_pc_next = i_redirect_valid            ? w_pc_aligned :
                             (w_ar_hs && !r_ar_stale)    ? r_fetch_pc + ADDR_WIDTH'(c_inc) :
                                                           r_fetch_pc;

    assign w_state_next = i_redirect_valid         ? RUN  :
                          (w_push && w_beat_err)   ? HALT : r_state;

    assign w_out_next  = r_outstanding + c_cnt_w'(w_ar_hs) - c_cnt_w'(w_r_retire);
    assign w_drop_load = r_outstanding - c_cnt_w'(w_r_retire) + c_cnt_w'(r_arvalid);
    assign w_occ_next  = i_redirect_valid ? '0 :
                         w_fifo_count + c_occ_w'(w_push) - c_occ_w'(w_pop);
    assign w_sum       = c_sum_w'(w_out_next) + c_sum_w'(w_occ_next);

    // Every in-flight request owns a FIFO slot, so R can always be accepted.
    assign w_issue = !i_redirect_valid && (w_state_next == RUN) &&
                     (!r_arvalid || w_ar_hs) &&
                     (w_out_next < c_cnt_w'(MAX_OUTSTANDING)) &&
                     (w_sum < c_sum_w'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_rpc         <= RESET_PC;
            r_araddr      <= RESET_PC;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_ar_stale    <= 1'b0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_rready      <= 1'b1;
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_outstanding <= w_out_next;

            if (w_issue) begin
                r_arvalid <= 1'b1;
                r_araddr  <= w_fetch_pc_next;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end

            if (i_redirect_valid && r_arvalid && !w_ar_hs) begin
                r_ar_stale <= 1'b1;
            end else if (w_ar_hs) begin
                r_ar_stale <= 1'b0;
            end

            if (i_redirect_valid) begin
                r_drop_cnt <= w_drop_load;
            end else if (w_r_hs && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end

            if (i_redirect_valid) begin
                r_rpc <= w_pc_aligned;
            end else if (w_push) begin
                r_rpc <= r_rpc + ADDR_WIDTH'(c_inc);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_fifo_w)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_redirect_valid),
        .i_push  (w_push),
        .i_data  ({w_beat_err, r_rpc, i_axil_rdata}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_valid (o_instr_valid),
        .o_count (w_fifo_count)
    );

    assign o_instr_err    = w_fifo_rd[c_fifo_w-1];
    assign o_instr_pc     = w_fifo_rd[DATA_WIDTH +: ADDR_WIDTH];
    assign o_instr        = w_fifo_rd[DATA_WIDTH-1:0];
    assign o_axil_araddr  = r_araddr;
    assign o_axil_arvalid = r_arvalid;
    assign o_axil_arprot  = C_ARPROT_INSTR;
    assign o_axil_rready  = r_rready;

endmodule

`default_nettype wire
